// File: rtl/spi_defs.sv
// Shared definitions for the SPI initiator: FSM states, frame geometry and
// the helper that packs a host request into the 16-bit shift frame.
package spi_defs;

  typedef enum logic [2:0] {
    IDLE,
    SETUP,
    HIGH,
    LOW,
    GAP
  } spi_state_t;

  localparam int SPI_FRAME_BITS = 16;
  localparam int SPI_ADDR_BITS  = 7;
  localparam int SPI_DATA_BITS  = 8;

  localparam logic SPI_RW_READ = 1'b1;

  // Reads send an all-zero data byte so the peripheral sees a clean slot.
  function automatic logic [SPI_FRAME_BITS-1:0] build_frame(
    input logic [SPI_ADDR_BITS-1:0] addr,
    input logic                     rw,
    input logic [SPI_DATA_BITS-1:0] wdata
  );
    return {addr, rw, (rw == SPI_RW_READ) ? {SPI_DATA_BITS{1'b0}} : wdata};
  endfunction

endpackage

// File: rtl/spi_clk_gen.sv
// Phase timer for the SPI engine: counts clk cycles inside one sclk
// half-period and strobes on the last cycle of each phase.
module spi_clk_gen #(
  parameter int CLKDIV = 4
) (
  input  logic clk,
  input  logic reset,
  input  logic run,
  output logic phase_end
);

  localparam int CNT_W = $clog2(CLKDIV);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(CLKDIV - 1);

  logic [CNT_W-1:0] cnt;

  assign phase_end = run && (cnt == CNT_LAST);

  // Restart from zero at every phase boundary and whenever the bus is idle.
  always_ff @(posedge clk) begin
    if (reset || !run || phase_end) begin
      cnt <= '0;
    end else begin
      cnt <= cnt + CNT_W'(1);
    end
  end

endmodule

// File: rtl/spi_master_sequencer.sv
// SPI initiator: accepts one request, frames it with cs/sclk, shifts the
// 16-bit frame out on mosi and returns the captured read byte.
module spi_master_sequencer
  import spi_defs::*;
#(
  parameter int CLKDIV = 4,
  parameter int CSGAP  = 2
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     req_valid,
  output logic                     req_ready,
  input  logic [SPI_ADDR_BITS-1:0] req_addr,
  input  logic                     req_rw,
  input  logic [SPI_DATA_BITS-1:0] req_wdata,
  output logic                     rsp_valid,
  output logic [SPI_DATA_BITS-1:0] rsp_rdata,
  output logic                     busy,
  output logic                     cs,
  output logic                     sclk,
  output logic                     mosi,
  input  logic                     miso
);

  localparam int GAP_W = (CSGAP > 1) ? $clog2(CSGAP) : 1;
  localparam logic [GAP_W-1:0] GAP_LAST = GAP_W'(CSGAP - 1);

  spi_state_t state, next_state;

  logic                      phase_end;
  logic                      run;
  logic                      accept;
  logic                      gap_last;
  logic [3:0]                bit_cnt;
  logic [GAP_W-1:0]          gap_cnt;
  logic [SPI_FRAME_BITS-1:0] shreg;
  logic [SPI_DATA_BITS-1:0]  cap;
  logic                      rw_q;

  assign req_ready = (state == IDLE) && !reset;
  assign accept    = req_valid && req_ready;
  assign run       = state inside {SETUP, HIGH, LOW};
  assign gap_last  = (gap_cnt == GAP_LAST);
  assign mosi      = shreg[SPI_FRAME_BITS-1];

  spi_clk_gen #(
    .CLKDIV(CLKDIV)
  ) u_clk_gen (
    .clk      (clk),
    .reset    (reset),
    .run      (run),
    .phase_end(phase_end)
  );

  // State register.
  always_ff @(posedge clk) begin
    if (reset) begin
      state <= IDLE;
    end else begin
      state <= next_state;
    end
  end

  // Phase sequencing; bit_cnt wraps to 0 after the 16th HIGH, marking the hold LOW.
  always_comb begin
    next_state = state;
    case (state)
      IDLE:    if (accept) next_state = SETUP;
      SETUP:   if (phase_end) next_state = HIGH;
      HIGH:    if (phase_end) next_state = LOW;
      LOW:     if (phase_end) next_state = (bit_cnt == 4'd0) ? GAP : HIGH;
      GAP:     if (gap_last) next_state = IDLE;
      default: next_state = IDLE;
    endcase
  end

  // Frame shifting, miso capture, bit and gap counting.
  always_ff @(posedge clk) begin
    if (reset) begin
      shreg   <= '0;
      cap     <= '0;
      rw_q    <= 1'b0;
      bit_cnt <= '0;
      gap_cnt <= '0;
    end else begin
      gap_cnt <= (state == GAP && !gap_last) ? gap_cnt + GAP_W'(1) : '0;
      case (state)
        IDLE: begin
          if (accept) begin
            shreg   <= build_frame(req_addr, req_rw, req_wdata);
            rw_q    <= req_rw;
            cap     <= '0;
            bit_cnt <= '0;
          end
        end
        HIGH: begin
          if (phase_end) begin
            shreg   <= {shreg[SPI_FRAME_BITS-2:0], 1'b0};
            cap     <= {cap[SPI_DATA_BITS-2:0], miso};
            bit_cnt <= bit_cnt + 4'd1;
          end
        end
        GAP:     bit_cnt <= '0;
        default: ;
      endcase
    end
  end

  // Pin and status outputs are registered from the upcoming state.
  always_ff @(posedge clk) begin
    if (reset) begin
      cs        <= 1'b1;
      sclk      <= 1'b0;
      busy      <= 1'b0;
      rsp_valid <= 1'b0;
      rsp_rdata <= '0;
    end else begin
      cs        <= !(next_state inside {SETUP, HIGH, LOW});
      sclk      <= (next_state == HIGH);
      busy      <= (next_state != IDLE);
      rsp_valid <= (state == LOW) && (next_state == GAP);
      if ((state == LOW) && (next_state == GAP)) begin
        rsp_rdata <= (rw_q == SPI_RW_READ) ? cap : '0;
      end
    end
  end

endmodule

// File: tb/tb_spi_master_sequencer.sv
// Bench for spi_master_sequencer: two instances (CLKDIV=4/CSGAP=2 and
// CLKDIV=2/CSGAP=1) share the host inputs; each has its own peripheral
// model, a timeline model checked every cycle, and transaction monitors.
module tb_spi_master_sequencer;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic       req_valid = 1'b0;
  logic [6:0] req_addr = '0;
  logic       req_rw = 1'b0;
  logic [7:0] req_wdata = '0;
  logic [7:0] pdata = '0;
  logic       chk_en = 1'b0;
  int         checks = 0;
  int         errors = 0;
  int         cyc = 0;

  // Free-running clock.
  always #5 clk = ~clk;

  // Cycle index used for gap measurements.
  always @(posedge clk) cyc <= cyc + 1;

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("[TB] FAIL %s actual=%0h required=%0h t=%0t", name, act, exp, $time);
    end
  endtask

  // Expected {cs, sclk, mosi, busy, rsp_valid} at 'off' cycles after accept.
  function automatic logic [4:0] model_pins(input int off, input int c, input logic [15:0] fr);
    int p;
    int k;
    if (off == 0) return 5'b10000;
    if (off > 33 * c) return {1'b1, 1'b0, 1'b0, 1'b1, (off == 33 * c + 1)};
    p = (off - 1) / c;
    if (p == 0) return {1'b0, 1'b0, fr[15], 1'b1, 1'b0};
    if (p % 2 == 1) begin
      k = (p + 1) / 2;
      return {1'b0, 1'b1, fr[16-k], 1'b1, 1'b0};
    end
    k = p / 2;
    if (k < 16) return {1'b0, 1'b0, fr[15-k], 1'b1, 1'b0};
    return 5'b00010;
  endfunction

  for (genvar gi = 0; gi < 2; gi++) begin : g_chk
    localparam int C      = (gi == 0) ? 4 : 2;
    localparam int G      = (gi == 0) ? 2 : 1;
    localparam int CS_LOW = 33 * C;

    logic       req_ready, rsp_valid, busy, cs, sclk, mosi;
    logic       miso = 1'b0;
    logic [7:0] rsp_rdata;

    int         off = 0;
    logic [15:0] m_frame = '0;
    logic [7:0] m_rd_pending = '0;
    logic [7:0] m_rd = '0;

    int         rise_cnt = 0, cs_low_cnt = 0, rise_cyc = 0, gap = -1;
    int         rsp_cnt = 0, last_rises = 0, last_cs_low = 0;
    logic [15:0] mosi_acc = '0, last_frame = '0;
    logic       prev_cs = 1'b1, prev_sclk = 1'b0;

    spi_master_sequencer #(
      .CLKDIV(C),
      .CSGAP (G)
    ) u_dut (
      .clk      (clk),
      .reset    (reset),
      .req_valid(req_valid),
      .req_ready(req_ready),
      .req_addr (req_addr),
      .req_rw   (req_rw),
      .req_wdata(req_wdata),
      .rsp_valid(rsp_valid),
      .rsp_rdata(rsp_rdata),
      .busy     (busy),
      .cs       (cs),
      .sclk     (sclk),
      .mosi     (mosi),
      .miso     (miso)
    );

    // Compare against the timeline model, then advance it for the next edge.
    always @(negedge clk) begin
      if (chk_en) begin
        checkOutput($sformatf("pins%0d_off%0d", gi, off),
                    32'({cs, sclk, mosi, busy, rsp_valid}), 32'(model_pins(off, C, m_frame)));
        checkOutput($sformatf("req_ready%0d", gi), 32'(req_ready), 32'(off == 0 && !reset));
        checkOutput($sformatf("rsp_rdata%0d", gi), 32'(rsp_rdata), 32'(m_rd));
      end
      if (reset) begin
        off  = 0;
        m_rd = '0;
      end else if (off == 0) begin
        if (req_valid) begin
          off          = 1;
          m_frame      = {req_addr, req_rw, req_rw ? 8'h00 : req_wdata};
          m_rd_pending = req_rw ? pdata : 8'h00;
        end
      end else begin
        off++;
        if (off == CS_LOW + 1) m_rd = m_rd_pending;
        if (off > CS_LOW + G) off = 0;
      end
    end

    // Peripheral: drives pdata on rises 9..16, records mosi and frame timing.
    always @(negedge clk) begin
      if (chk_en) begin
        if (rsp_valid) rsp_cnt++;
        if (!cs) begin
          cs_low_cnt++;
          if (prev_cs) gap = cyc - rise_cyc;
          if (sclk && !prev_sclk) begin
            rise_cnt++;
            mosi_acc = {mosi_acc[14:0], mosi};
            miso = (rise_cnt >= 9) ? pdata[16-rise_cnt] : 1'(rise_cnt % 2);
          end
        end else if (!prev_cs) begin
          last_cs_low = cs_low_cnt;
          last_rises  = rise_cnt;
          last_frame  = mosi_acc;
          cs_low_cnt  = 0;
          rise_cnt    = 0;
          mosi_acc    = '0;
          rise_cyc    = cyc;
          miso        = 1'b0;
        end
      end
      prev_cs   = cs;
      prev_sclk = sclk;
    end
  end

  task automatic tick(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic waitAccept();
    for (int n = 0; n < 1000; n++) begin
      if (g_chk[0].req_ready) begin
        tick(1);
        return;
      end
      tick(1);
    end
    checkOutput("accept_timeout", 32'd0, 32'd1);
  endtask

  task automatic waitRsp(input int target);
    int n = 0;
    while (g_chk[0].rsp_cnt < target && n < 2000) begin
      tick(1);
      n++;
    end
    checkOutput("rsp_timeout", 32'(g_chk[0].rsp_cnt >= target), 32'd1);
  endtask

  task automatic applyStimulus(input logic [6:0] addr, input logic rw,
                               input logic [7:0] wdata, input logic [7:0] pd);
    pdata     = pd;
    req_addr  = addr;
    req_rw    = rw;
    req_wdata = wdata;
    req_valid = 1'b1;
    waitAccept();
    req_valid = 1'b0;
  endtask

  // Watchdog so the run always ends.
  initial begin
    #400000;
    $display("[TB] FAIL watchdog expired actual=running required=finished");
    $fatal(1, "[TB] watchdog");
  end

  // Directed test sequence.
  initial begin
    int r0;
    int r1;

    tick(1);
    chk_en = 1'b1;
    checkOutput("reset_cs", 32'(g_chk[0].cs), 32'd1);
    checkOutput("reset_sclk", 32'(g_chk[0].sclk), 32'd0);
    checkOutput("reset_mosi", 32'(g_chk[0].mosi), 32'd0);
    checkOutput("reset_ready", 32'(g_chk[0].req_ready), 32'd0);
    checkOutput("reset_busy", 32'(g_chk[0].busy), 32'd0);
    checkOutput("reset_rdata", 32'(g_chk[0].rsp_rdata), 32'd0);
    tick(2);
    reset = 1'b0;
    #1;
    checkOutput("ready_after_reset", 32'(g_chk[0].req_ready), 32'd1);
    tick(1);

    $display("[TB] write 2A/C3");
    r0 = g_chk[0].rsp_cnt;
    r1 = g_chk[1].rsp_cnt;
    applyStimulus(7'h2A, 1'b0, 8'hC3, 8'h00);
    waitRsp(r0 + 1);
    tick(4);
    checkOutput("wr_frame", 32'(g_chk[0].last_frame), 32'h54C3);
    checkOutput("wr_cs_low", 32'(g_chk[0].last_cs_low), 32'd132);
    checkOutput("wr_rises", 32'(g_chk[0].last_rises), 32'd16);
    checkOutput("wr_rdata", 32'(g_chk[0].rsp_rdata), 32'h00);
    checkOutput("wr_rsp_count", 32'(g_chk[0].rsp_cnt - r0), 32'd1);
    checkOutput("fast_wr_cs_low", 32'(g_chk[1].last_cs_low), 32'd66);
    checkOutput("fast_wr_rises", 32'(g_chk[1].last_rises), 32'd16);
    checkOutput("fast_wr_frame", 32'(g_chk[1].last_frame), 32'h54C3);
    checkOutput("fast_wr_rsp_count", 32'(g_chk[1].rsp_cnt - r1), 32'd1);

    $display("[TB] read 05 -> A5");
    applyStimulus(7'h05, 1'b1, 8'hFF, 8'hA5);
    waitRsp(r0 + 2);
    tick(4);
    checkOutput("rd_frame", 32'(g_chk[0].last_frame), 32'h0B00);
    checkOutput("rd_rdata", 32'(g_chk[0].rsp_rdata), 32'hA5);
    checkOutput("fast_rd_frame", 32'(g_chk[1].last_frame), 32'h0B00);
    checkOutput("fast_rd_rdata", 32'(g_chk[1].rsp_rdata), 32'hA5);
    checkOutput("fast_rd_cs_low", 32'(g_chk[1].last_cs_low), 32'd66);

    $display("[TB] back-to-back");
    r0 = g_chk[0].rsp_cnt;
    pdata     = 8'h00;
    req_addr  = 7'h11;
    req_rw    = 1'b0;
    req_wdata = 8'h5A;
    req_valid = 1'b1;
    waitAccept();
    req_addr  = 7'h33;
    req_wdata = 8'h96;
    waitAccept();
    req_valid = 1'b0;
    waitRsp(r0 + 2);
    tick(4);
    checkOutput("b2b_gap", 32'(g_chk[0].gap), 32'd3);
    checkOutput("b2b_rsp_count", 32'(g_chk[0].rsp_cnt - r0), 32'd2);
    checkOutput("b2b_frame2", 32'(g_chk[0].last_frame), 32'h6696);

    $display("[TB] reset after 5th rise");
    r0 = g_chk[0].rsp_cnt;
    pdata     = 8'h00;
    req_addr  = 7'h44;
    req_rw    = 1'b0;
    req_wdata = 8'h3C;
    req_valid = 1'b1;
    waitAccept();
    req_valid = 1'b0;
    for (int n = 0; n < 500 && g_chk[0].rise_cnt < 5; n++) tick(1);
    checkOutput("rise5_reached", 32'(g_chk[0].rise_cnt), 32'd5);
    reset = 1'b1;
    tick(1);
    checkOutput("abort_cs", 32'(g_chk[0].cs), 32'd1);
    checkOutput("abort_sclk", 32'(g_chk[0].sclk), 32'd0);
    reset = 1'b0;
    #1;
    checkOutput("abort_ready", 32'(g_chk[0].req_ready), 32'd1);
    tick(200);
    checkOutput("abort_no_rsp", 32'(g_chk[0].rsp_cnt - r0), 32'd0);
    applyStimulus(7'h7F, 1'b0, 8'h81, 8'h00);
    waitRsp(r0 + 1);
    tick(4);
    checkOutput("post_abort_frame", 32'(g_chk[0].last_frame), 32'hFE81);
    checkOutput("post_abort_rdata", 32'(g_chk[0].rsp_rdata), 32'h00);

    $display("[TB] fields change while busy");
    r0 = g_chk[0].rsp_cnt;
    applyStimulus(7'h3C, 1'b1, 8'h00, 8'h5E);
    for (int n = 0; n < 40; n++) begin
      req_valid = 1'b1;
      req_addr  = 7'($urandom);
      req_rw    = 1'($urandom);
      req_wdata = 8'($urandom);
      #1;
      checkOutput("ready_while_busy", 32'(g_chk[0].req_ready), 32'd0);
      tick(1);
    end
    req_valid = 1'b0;
    waitRsp(r0 + 1);
    tick(4);
    checkOutput("latched_frame", 32'(g_chk[0].last_frame), 32'h7900);
    checkOutput("latched_rdata", 32'(g_chk[0].rsp_rdata), 32'h5E);
    checkOutput("fast_latched_frame", 32'(g_chk[1].last_frame), 32'h7900);
    checkOutput("fast_latched_rdata", 32'(g_chk[1].rsp_rdata), 32'h5E);

    tick(10);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
